// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the shift_seq_ctrl command sequencer: register ctrl codes,
// command opcodes, FSM state encoding and default sizing.
package shift_seq_ctrl_pkg;

  localparam int N_DEF     = 4;
  localparam int CNT_W_DEF = 3;

  localparam logic [1:0] CTRL_STORE = 2'b00;
  localparam logic [1:0] CTRL_LOAD  = 2'b01;
  localparam logic [1:0] CTRL_LS    = 2'b10;
  localparam logic [1:0] CTRL_RS    = 2'b11;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_SHR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  // Both shift opcodes share the high bit.
  function automatic logic is_shift_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/shift_amt_counter.sv
// Loadable down counter for the remaining shift count; last flags the final shift cycle.
module shift_amt_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] count_r;

  // Count register: load wins over decrement, never wraps below zero.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != '0)) begin
      count_r <= count_r - CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign last  = (count_r == CNT_W'(1));

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer feeding the load/store/shift register. Define SHIFT_SEQ_ROTATE_EN
// to add reg_q/cmd_rot ports and a combinational rotate path for ls/rs.
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_amt,
  input  logic             cmd_fill,
  input  logic [N-1:0]     cmd_data,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic [N-1:0]     reg_q,
  input  logic             cmd_rot,
`endif
  output logic [1:0]       reg_ctrl,
  output logic             reg_ls,
  output logic             reg_rs,
  output logic [N-1:0]     reg_data,
  output logic             busy,
  output logic             done
);

  state_t           state_r, state_nxt_s;
  logic             accept_s;
  logic [1:0]       op_r;
  logic             fill_r;
  logic             shl_nxt_s, fill_nxt_s;
  logic [1:0]       ctrl_nxt_s;
  logic             ls_nxt_s, rs_nxt_s;
  logic [1:0]       reg_ctrl_r;
  logic             reg_ls_r, reg_rs_r, busy_r, done_r;
  logic [N-1:0]     reg_data_r;
  logic [CNT_W-1:0] cnt_s;
  logic             last_s;

  assign accept_s = cmd_valid && (state_r == ST_IDLE);

  shift_amt_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .clr      (clr),
    .load     (accept_s),
    .dec      (state_r == ST_SHIFT),
    .load_val (cmd_amt),
    .count    (cnt_s),
    .last     (last_s)
  );

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!accept_s) begin
          state_nxt_s = ST_IDLE;
        end else if (cmd_op == OP_LOAD) begin
          state_nxt_s = ST_LOAD;
        end else if (is_shift_op(cmd_op) && (cmd_amt != '0)) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      ST_LOAD:  state_nxt_s = ST_DONE;
      ST_SHIFT: state_nxt_s = last_s ? ST_DONE : ST_SHIFT;
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with it once registered.
  always_comb begin
    shl_nxt_s  = (state_r == ST_IDLE) ? (cmd_op == OP_SHL) : (op_r == OP_SHL);
    fill_nxt_s = (state_r == ST_IDLE) ? cmd_fill : fill_r;
    ctrl_nxt_s = CTRL_STORE;
    ls_nxt_s   = 1'b0;
    rs_nxt_s   = 1'b0;
    if (state_nxt_s == ST_SHIFT) begin
      ctrl_nxt_s = shl_nxt_s ? CTRL_LS : CTRL_RS;
      ls_nxt_s   = shl_nxt_s & fill_nxt_s;
      rs_nxt_s   = ~shl_nxt_s & fill_nxt_s;
    end else if (state_nxt_s == ST_LOAD) begin
      ctrl_nxt_s = CTRL_LOAD;
    end else begin
      ctrl_nxt_s = CTRL_STORE;
    end
  end

  // State, captured command fields and registered outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r    <= ST_IDLE;
      op_r       <= OP_NOP;
      fill_r     <= 1'b0;
      reg_ctrl_r <= CTRL_STORE;
      reg_ls_r   <= 1'b0;
      reg_rs_r   <= 1'b0;
      reg_data_r <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      reg_ctrl_r <= ctrl_nxt_s;
      reg_ls_r   <= ls_nxt_s;
      reg_rs_r   <= rs_nxt_s;
      busy_r     <= (state_nxt_s != ST_IDLE);
      done_r     <= (state_nxt_s == ST_DONE);
      if (accept_s) begin
        op_r   <= cmd_op;
        fill_r <= cmd_fill;
      end else begin
        op_r   <= op_r;
        fill_r <= fill_r;
      end
      if (state_nxt_s == ST_LOAD) begin
        reg_data_r <= cmd_data;
      end else begin
        reg_data_r <= reg_data_r;
      end
    end
  end

`ifdef SHIFT_SEQ_ROTATE_EN
  logic rot_r;

  // Rotate select captured with the command.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rot_r <= 1'b0;
    end else if (accept_s) begin
      rot_r <= cmd_rot;
    end else begin
      rot_r <= rot_r;
    end
  end

  // Rotation feeds the register's own end bit back in, so it cannot be pre-registered.
  assign reg_ls = (rot_r && (state_r == ST_SHIFT) && (op_r == OP_SHL)) ? reg_q[N-1] : reg_ls_r;
  assign reg_rs = (rot_r && (state_r == ST_SHIFT) && (op_r == OP_SHR)) ? reg_q[0]   : reg_rs_r;
`else
  assign reg_ls = reg_ls_r;
  assign reg_rs = reg_rs_r;
`endif

  assign cmd_ready = (state_r == ST_IDLE);
  assign reg_ctrl  = reg_ctrl_r;
  assign reg_data  = reg_data_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed and random commands against a
// command-level model of the downstream register. Honors SHIFT_SEQ_ROTATE_EN.
module tb_shift_seq_ctrl;
  localparam int N     = 4;
  localparam int CNT_W = 3;
  localparam int FULL  = (1 << N) - 1;

  logic             clk = 1'b0;
  logic             clr = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_amt = '0;
  logic             cmd_fill = 1'b0;
  logic [N-1:0]     cmd_data = '0;
  logic             cmd_rot = 1'b0;
  logic [1:0]       reg_ctrl;
  logic             reg_ls, reg_rs, busy, done;
  logic [N-1:0]     reg_data;

  logic [N-1:0]     q = '0;
  int               exp_q = 0;
  int               last_load = 0;
  int               vectors = 0;
  int               miscompares = 0;

  shift_seq_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .clr       (clr),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_amt   (cmd_amt),
    .cmd_fill  (cmd_fill),
    .cmd_data  (cmd_data),
`ifdef SHIFT_SEQ_ROTATE_EN
    .reg_q     (q),
    .cmd_rot   (cmd_rot),
`endif
    .reg_ctrl  (reg_ctrl),
    .reg_ls    (reg_ls),
    .reg_rs    (reg_rs),
    .reg_data  (reg_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Downstream load/store/shift register
  always @(posedge clk) begin
    case (reg_ctrl)
      2'b01:   q <= reg_data;
      2'b10:   q <= {q[N-2:0], reg_ls};
      2'b11:   q <= {reg_rs, q[N-1:1]};
      default: q <= q;
    endcase
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Issue one command at a negedge with the DUT idle; check every cycle until idle again.
  task automatic run_cmd(input logic [1:0] op, input int amt, input logic fill,
                         input logic [N-1:0] data, input logic rot, input logic hold);
    int n_ops;
    int k;
    logic rot_eff;
`ifdef SHIFT_SEQ_ROTATE_EN
    rot_eff = rot;
`else
    rot_eff = 1'b0;
`endif
    n_ops = (op == 2'b01) ? 1 : ((op[1] && amt != 0) ? amt : 0);
    if (op == 2'b01) begin
      exp_q = int'(data);
      last_load = int'(data);
    end else if (op == 2'b10 && amt != 0) begin
      if (rot_eff) begin
        k = amt % N;
        exp_q = ((exp_q << k) | (exp_q >> (N - k))) & FULL;
      end else begin
        exp_q = ((exp_q << amt) | (fill ? ((1 << amt) - 1) : 0)) & FULL;
      end
    end else if (op == 2'b11 && amt != 0) begin
      if (rot_eff) begin
        k = amt % N;
        exp_q = ((exp_q >> k) | (exp_q << (N - k))) & FULL;
      end else begin
        exp_q = (exp_q >> amt) | (fill ? (FULL & ~(FULL >> amt)) : 0);
      end
    end
    cmd_op = op; cmd_amt = CNT_W'(amt); cmd_fill = fill; cmd_data = data;
    cmd_rot = rot; cmd_valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < n_ops; i++) begin
      @(negedge clk);
      if (!hold) cmd_valid = 1'b0;
      check_val("op_ctrl", reg_ctrl, (op == 2'b01) ? 2'b01 : op);
      check_val("op_ls", reg_ls, (op == 2'b10) ? (rot_eff ? q[N-1] : fill) : 1'b0);
      check_val("op_rs", reg_rs, (op == 2'b11) ? (rot_eff ? q[0] : fill) : 1'b0);
      check_val("op_busy_rdy_done", {busy, cmd_ready, done}, 3'b100);
      if (op == 2'b01) check_val("load_data", reg_data, data);
    end
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
    check_val("done_ctrl", reg_ctrl, 2'b00);
    check_val("done_busy_rdy_done", {busy, cmd_ready, done}, 3'b101);
    @(negedge clk);
    check_val("idle_busy_rdy_done", {busy, cmd_ready, done}, 3'b010);
    check_val("idle_ctrl", reg_ctrl, 2'b00);
    check_val("idle_data_hold", reg_data, last_load);
    check_val("reg_value", q, exp_q);
  endtask

  initial begin
    logic [1:0]   r_op;
    int           r_amt;
    logic         r_fill, r_rot, r_hold;
    logic [N-1:0] r_data;

    repeat (3) @(negedge clk);
    check_val("rst_ctrl", reg_ctrl, 2'b00);
    check_val("rst_lsrs", {reg_ls, reg_rs}, 2'b00);
    check_val("rst_data", reg_data, 0);
    check_val("rst_busy_done", {busy, done}, 2'b00);
    clr = 1'b1;
    @(negedge clk);
    check_val("rst_ready", cmd_ready, 1'b1);

    run_cmd(2'b01, 0, 1'b0, 4'b1010, 1'b0, 1'b0);
    run_cmd(2'b10, 2, 1'b1, 4'b0000, 1'b0, 1'b0);
    run_cmd(2'b01, 0, 1'b0, 4'b1111, 1'b0, 1'b0);
    run_cmd(2'b11, 5, 1'b0, 4'b0000, 1'b0, 1'b0);
    run_cmd(2'b11, 0, 1'b1, 4'b0110, 1'b0, 1'b0);
    run_cmd(2'b00, 3, 1'b1, 4'b0110, 1'b0, 1'b0);
    run_cmd(2'b10, 7, 1'b1, 4'b0000, 1'b0, 1'b1);
    run_cmd(2'b10, 7, 1'b1, 4'b0000, 1'b0, 1'b0);
`ifdef SHIFT_SEQ_ROTATE_EN
    run_cmd(2'b01, 0, 1'b0, 4'b1000, 1'b0, 1'b0);
    run_cmd(2'b10, 1, 1'b0, 4'b0000, 1'b1, 1'b0);
    run_cmd(2'b11, 1, 1'b0, 4'b0000, 1'b1, 1'b0);
`endif

    // Reset in the middle of a 5-cycle shift
    cmd_op = 2'b11; cmd_amt = 3'd5; cmd_fill = 1'b0; cmd_rot = 1'b0; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); cmd_valid = 1'b0;
    @(posedge clk);
    #1 clr = 1'b0;
    #1;
    check_val("abort_ctrl", reg_ctrl, 2'b00);
    check_val("abort_busy_done", {busy, done}, 2'b00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("abort_no_done", done, 1'b0);
    end
    clr = 1'b1;
    last_load = 0;
    @(negedge clk);
    check_val("abort_idle", {busy, cmd_ready, done}, 3'b010);
    check_val("abort_data", reg_data, 0);
    run_cmd(2'b01, 0, 1'b0, 4'b0101, 1'b0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      r_op   = 2'($urandom_range(0, 3));
      r_amt  = $urandom_range(0, 7);
      r_fill = 1'($urandom_range(0, 1));
      r_data = N'($urandom);
      r_rot  = 1'($urandom_range(0, 1));
      r_hold = ($urandom_range(0, 7) == 0);
      run_cmd(r_op, r_amt, r_fill, r_data, r_rot, r_hold);
      if (r_hold) run_cmd(r_op, r_amt, r_fill, r_data, r_rot, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
